// File: rtl/atom_reader.sv
// Lock-and-read controller for an atomic register: freezes the source, waits
// for settling, then returns a value only when two back-to-back samples agree.
module atom_reader #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SETTLE       = 2,
  parameter int unsigned MAX_ATTEMPTS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  input  logic [WIDTH-1:0] reg_data,
  output logic             lock_out,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err
);

  localparam int unsigned CNT_W = $clog2(SETTLE) + 1;
  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);

  // The capture step is folded into the last WAIT edge, so no CAPT encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CMP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [WIDTH-1:0]   sample_q, sample_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               lock_q, lock_d;
  logic               busy_q, busy_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_err_q, rd_err_d;
  logic               match_c;

  assign match_c = (reg_data == sample_q);

  // State and output registers; reset drops the lock and discards any read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      att_q      <= '0;
      sample_q   <= '0;
      rd_data_q  <= '0;
      lock_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      att_q      <= att_d;
      sample_q   <= sample_d;
      rd_data_q  <= rd_data_d;
      lock_q     <= lock_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // Next-state, settle/attempt counters and first-sample capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    att_d    = att_q;
    sample_d = sample_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
          att_d   = ATT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sample_d = reg_data;
          state_d  = S_CMP;
        end
      end
      S_CMP: begin
        if (match_c) begin
          state_d = S_IDLE;
        end else if (att_q < ATT_MAX) begin
          att_d   = att_q + ATT_W'(1);
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: lock/busy follow the upcoming state, pulses come from the compare edge.
  always_comb begin
    lock_d     = 1'b0;
    busy_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    rd_data_d  = rd_data_q;
    if (state_d != S_IDLE) begin
      lock_d = 1'b1;
      busy_d = 1'b1;
    end
    if (state_q == S_CMP) begin
      if (match_c) begin
        rd_valid_d = 1'b1;
        rd_data_d  = sample_q;
      end else if (att_q >= ATT_MAX) begin
        rd_err_d = 1'b1;
      end
    end
  end

  assign lock_out = lock_q;
  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_atom_reader.sv
// Bench for atom_reader: a timeline model (attempt k compares at edge k*(SETTLE+1)
// after acceptance) checked every cycle, plus literal checks on directed scenarios.
module tb_atom_reader;

  localparam int unsigned WIDTH        = 8;
  localparam int unsigned SETTLE       = 2;
  localparam int unsigned MAX_ATTEMPTS = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_req;
  logic [WIDTH-1:0] reg_data;
  logic             lock_out;
  logic             busy;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  atom_reader #(
    .WIDTH(WIDTH), .SETTLE(SETTLE), .MAX_ATTEMPTS(MAX_ATTEMPTS)
  ) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .reg_data(reg_data),
    .lock_out(lock_out), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Model state: expected outputs after the most recent posedge.
  bit               m_busy = 1'b0;
  bit               m_valid = 1'b0;
  bit               m_err = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic [WIDTH-1:0] m_prev = '0;
  int               m_rel = 0;

  always @(posedge clk) begin
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!rst) begin
      m_busy = 1'b0;
      m_data = '0;
    end else if (!m_busy) begin
      if (rd_req) begin
        m_busy = 1'b1;
        m_rel  = 0;
      end
    end else begin
      m_rel = m_rel + 1;
      if (m_rel % (SETTLE + 1) == 0) begin
        if (reg_data == m_prev) begin
          m_valid = 1'b1;
          m_data  = reg_data;
          m_busy  = 1'b0;
        end else if (m_rel / (SETTLE + 1) == MAX_ATTEMPTS) begin
          m_err  = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
    m_prev = reg_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_lock",  32'(lock_out), 32'(m_busy));
      check("model_busy",  32'(busy),     32'(m_busy));
      check("model_valid", 32'(rd_valid), 32'(m_valid));
      check("model_err",   32'(rd_err),   32'(m_err));
      check("model_data",  32'(rd_data),  32'(m_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    rd_req   = 1'b0;
    reg_data = '0;
    tick();
    tick();
    check("reset_lock", 32'(lock_out), 32'd0);
    check("reset_busy", 32'(busy),     32'd0);
    check("reset_data", 32'(rd_data),  32'd0);
    rst    = 1'b1;
    chk_en = 1'b1;
    tick();

    // Reset mid-read: preload a value first so the reset clear is visible.
    reg_data = 8'h77;
    rd_req   = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_data", 32'(rd_data), 32'h77);
    rd_req = 1'b1;
    tick();                               // E0
    rd_req = 1'b0;
    rst    = 1'b0;
    tick();                               // E1: reset
    rst = 1'b1;
    check("rstmid_lock", 32'(lock_out), 32'd0);
    check("rstmid_busy", 32'(busy),     32'd0);
    check("rstmid_data", 32'(rd_data),  32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rstmid_nopulse", 32'(rd_valid | rd_err), 32'd0);
    end

    // Clean read of 0xA5.
    reg_data = 8'hA5;
    rd_req   = 1'b1;
    tick();                               // E0
    rd_req = 1'b0;
    check("clean_lock_e0", 32'(lock_out), 32'd1);
    tick();
    tick();                               // E2
    check("clean_lock_e2",  32'(lock_out), 32'd1);
    check("clean_valid_e2", 32'(rd_valid), 32'd0);
    tick();                               // E3
    check("clean_valid_e3", 32'(rd_valid), 32'd1);
    check("clean_data_e3",  32'(rd_data),  32'hA5);
    check("clean_lock_e3",  32'(lock_out), 32'd0);
    tick();
    check("clean_valid_e4", 32'(rd_valid), 32'd0);
    tick();

    // All mismatches: reg_data alternates 0x00/0xFF on every edge.
    reg_data = 8'h00;
    rd_req   = 1'b1;
    tick();                               // E0
    rd_req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      reg_data = ~reg_data;
      tick();                             // Ek
      check("mis_err",   32'(rd_err),   32'(k == 9));
      check("mis_valid", 32'(rd_valid), 32'd0);
    end
    check("mis_data", 32'(rd_data), 32'hA5);
    check("mis_lock", 32'(lock_out), 32'd0);
    tick();

    // One mismatch then match.
    reg_data = 8'h11;
    rd_req   = 1'b1;
    tick();                               // E0
    rd_req = 1'b0;
    tick();
    tick();                               // E2: samples 0x11
    reg_data = 8'h12;
    tick();                               // E3
    check("retry_nopulse_e3", 32'(rd_valid | rd_err), 32'd0);
    check("retry_lock_e3",    32'(lock_out), 32'd1);
    tick();
    tick();
    check("retry_valid_e5", 32'(rd_valid), 32'd0);
    tick();                               // E6
    check("retry_valid_e6", 32'(rd_valid), 32'd1);
    check("retry_data_e6",  32'(rd_data),  32'h12);
    tick();

    // Back-to-back with rd_req held.
    reg_data = 8'h3C;
    rd_req   = 1'b1;
    tick();                               // E0
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("b2b_valid", 32'(rd_valid), 32'(k == 3 || k == 7));
      check("b2b_lock",  32'(lock_out), 32'(k != 3 && k != 7));
      check("b2b_busy",  32'(busy),     32'(k != 3 && k != 7));
    end
    check("b2b_data", 32'(rd_data), 32'h3C);
    rd_req = 1'b0;
    tick();
    tick();

    // Extra requests while busy are ignored.
    reg_data = 8'h5A;
    rd_req   = 1'b1;
    tick();                               // E0
    tick();                               // E1
    tick();                               // E2
    rd_req = 1'b0;
    tick();                               // E3
    check("busyreq_valid_e3", 32'(rd_valid), 32'd1);
    check("busyreq_data_e3",  32'(rd_data),  32'h5A);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("busyreq_idle", 32'({busy, lock_out, rd_valid, rd_err}), 32'd0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
